// File: rtl/ccff_loader.sv
// Configuration-chain loader: streams bitstream words MSB first into a scan chain and
// optionally recirculates the chain once to compare CRCs of the sent and read-back data.
module ccff_loader #(
    parameter int CHAIN_LEN = 58,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              verify_en,
    input  logic [WORD_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              verify_ok,
    output logic              verify_err
);

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int RW = $clog2(WORD_W + 1);
    localparam logic [CW-1:0] ChainLenC = CW'(CHAIN_LEN);
    localparam logic [15:0]   CrcInit   = 16'hFFFF;

    typedef enum logic [2:0] {StIdle, StLoad, StShift, StVerify, StCheck, StFin} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, remaining;
    logic [RW-1:0]     rem_q, rem_d, word_bits;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic              head_q, head_d;
    logic              verify_q, verify_d;
    logic              ok_d, err_d;
    logic [15:0]       crc_tx_q, crc_tx_d, crc_rx_q, crc_rx_d;

    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[15] ^ b;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // During readback the head must follow the live tail, so it bypasses head_q.
    assign ccff_head = (state_q == StVerify) ? ccff_tail : head_q;

    always_comb begin
        remaining = ChainLenC - cnt_q;
        if (int'(remaining) < WORD_W) word_bits = RW'(remaining);
        else                          word_bits = RW'(WORD_W);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        shreg_d  = shreg_q;
        head_d   = 1'b0;
        verify_d = verify_q;
        crc_tx_d = crc_tx_q;
        crc_rx_d = crc_rx_q;
        ok_d     = verify_ok;
        err_d    = verify_err;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StLoad;
                    cnt_d    = '0;
                    verify_d = verify_en;
                    ok_d     = 1'b0;
                    err_d    = 1'b0;
                    crc_tx_d = CrcInit;
                    crc_rx_d = CrcInit;
                end
            end
            StLoad: begin
                if (data_valid && data_ready) begin
                    state_d = StShift;
                    head_d  = data_in[WORD_W-1];
                    shreg_d = data_in << 1;
                    rem_d   = word_bits;
                end
            end
            StShift: begin
                crc_tx_d = crc_step(crc_tx_q, head_q);
                cnt_d    = cnt_q + CW'(1);
                rem_d    = rem_q - RW'(1);
                if (rem_q == RW'(1)) begin
                    if (cnt_q + CW'(1) < ChainLenC) begin
                        state_d = StLoad;
                    end else if (verify_q) begin
                        state_d = StVerify;
                        cnt_d   = '0;
                    end else begin
                        state_d = StFin;
                    end
                end else begin
                    head_d  = shreg_q[WORD_W-1];
                    shreg_d = shreg_q << 1;
                end
            end
            StVerify: begin
                crc_rx_d = crc_step(crc_rx_q, ccff_tail);
                if (cnt_q == ChainLenC - CW'(1)) begin
                    state_d = StCheck;
                    cnt_d   = ChainLenC;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StCheck: begin
                ok_d    = (crc_tx_q == crc_rx_q);
                err_d   = (crc_tx_q != crc_rx_q);
                state_d = StFin;
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            rem_q         <= '0;
            shreg_q       <= '0;
            head_q        <= 1'b0;
            verify_q      <= 1'b0;
            crc_tx_q      <= CrcInit;
            crc_rx_q      <= CrcInit;
            data_ready    <= 1'b0;
            ccff_shift_en <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            verify_ok     <= 1'b0;
            verify_err    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            shreg_q       <= shreg_d;
            head_q        <= head_d;
            verify_q      <= verify_d;
            crc_tx_q      <= crc_tx_d;
            crc_rx_q      <= crc_rx_d;
            data_ready    <= (state_d == StLoad);
            ccff_shift_en <= (state_d == StShift) || (state_d == StVerify);
            busy          <= (state_d != StIdle);
            done          <= (state_d == StFin);
            verify_ok     <= ok_d;
            verify_err    <= err_d;
        end
    end

endmodule

// File: tb/tb_ccff_loader.sv
// Self-checking bench for ccff_loader: random bitstreams into a behavioural scan-chain model,
// checked against a stream/CRC model built from plain bit lists.
module tb_ccff_loader;

    localparam int L  = 58;
    localparam int W  = 8;
    localparam int NW = (L + W - 1) / W;

    logic         prog_clk = 1'b0;
    logic         pReset = 1'b1;
    logic         start = 1'b0;
    logic         verify_en = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         data_valid = 1'b0;
    logic         data_ready, ccff_head, ccff_shift_en, ccff_tail;
    logic         busy, done, verify_ok, verify_err;

    ccff_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
        .prog_clk     (prog_clk),
        .pReset       (pReset),
        .start        (start),
        .verify_en    (verify_en),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .ccff_head    (ccff_head),
        .ccff_shift_en(ccff_shift_en),
        .ccff_tail    (ccff_tail),
        .busy         (busy),
        .done         (done),
        .verify_ok    (verify_ok),
        .verify_err   (verify_err)
    );

    always #5 prog_clk = ~prog_clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Chain model: index L-1 is the tail flop, index 0 takes the head.
    logic [L-1:0] chain = '0;
    logic [L-1:0] load_img = '0;
    int           chain_shifts = 0;
    bit           mon_clr = 1'b0;
    bit           flip_req = 1'b0;

    assign ccff_tail = chain[L-1];

    function automatic logic [L-1:0] chain_next(input logic [L-1:0] c, input logic h,
                                                input bit flip);
        logic [L-1:0] n;
        n = {c[L-2:0], h};
        if (flip) n[20] = ~n[20];
        return n;
    endfunction

    always @(posedge prog_clk) begin
        if (mon_clr) begin
            chain_shifts <= 0;
        end else if (ccff_shift_en) begin
            chain        <= chain_next(chain, ccff_head, flip_req && chain_shifts == L - 1);
            chain_shifts <= chain_shifts + 1;
            if (chain_shifts == L - 1)
                load_img <= chain_next(chain, ccff_head, flip_req);
        end
    end

    int cyc = 0, sh_cnt = 0, done_cnt = 0, head_viol = 0, rs_viol = 0, gap_err = 0;
    int bits_acc = 0, xfer_cyc = 0, exp_k = 0;
    bit pend = 1'b0;

    function automatic int word_k(input int sent);
        return (L - sent < W) ? L - sent : W;
    endfunction

    always @(negedge prog_clk) begin
        cyc <= cyc + 1;
        if (mon_clr) begin
            sh_cnt <= 0; done_cnt <= 0; head_viol <= 0; rs_viol <= 0; gap_err <= 0;
            bits_acc <= 0; pend <= 1'b0;
        end else begin
            if (ccff_shift_en) sh_cnt <= sh_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (!ccff_shift_en && ccff_head) head_viol <= head_viol + 1;
            if (data_ready && ccff_shift_en) rs_viol <= rs_viol + 1;
            if (data_ready && data_valid) begin
                xfer_cyc <= cyc;
                exp_k    <= word_k(bits_acc);
                bits_acc <= bits_acc + word_k(bits_acc);
                pend     <= 1'b1;
            end else if (pend && data_ready) begin
                if (cyc - xfer_cyc != exp_k + 1) gap_err <= gap_err + 1;
                pend <= 1'b0;
            end
        end
    end

    logic [W-1:0] words [NW];

    function automatic logic [15:0] crc_seq(input logic [L-1:0] v);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = L - 1; i >= 0; i--) begin
            fb = c[15] ^ v[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // Expected chain image: stream bit n lands at index L-1-n after L shifts.
    function automatic logic [L-1:0] stream_image();
        logic [L-1:0] img;
        int           n;
        img = '0;
        n   = 0;
        for (int w = 0; w < NW; w++)
            for (int j = W - 1; j >= 0; j--)
                if (n < L) begin
                    img[L-1-n] = words[w][j];
                    n++;
                end
        return img;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"}, 64'(data_ready), 64'd0);
        check_val({tag, "_shift_en"}, 64'(ccff_shift_en), 64'd0);
        check_val({tag, "_head"}, 64'(ccff_head), 64'd0);
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_done"}, 64'(done), 64'd0);
        check_val({tag, "_ok"}, 64'(verify_ok), 64'd0);
        check_val({tag, "_err"}, 64'(verify_err), 64'd0);
    endtask

    task automatic run_load(input string tag, input bit v, input bit flip, input int stall_after,
                            input bit glitch, input int abort_at);
        int           idx, stall;
        bit           xfer, fin, g2;
        logic [L-1:0] exp_load, mask;
        logic         ok_exp;
        idx = 0; stall = 0; fin = 1'b0; g2 = 1'b0;
        mon_clr  = 1'b1;
        flip_req = flip;
        @(posedge prog_clk); #1;
        mon_clr   = 1'b0;
        start     = 1'b1;
        verify_en = v;
        @(posedge prog_clk); #1;
        start     = 1'b0;
        verify_en = 1'b0;
        check_val({tag, "_busy_after_start"}, 64'(busy), 64'd1);
        data_valid = 1'b1;
        data_in    = words[0];
        for (int c = 0; c < 1500 && !fin; c++) begin
            @(negedge prog_clk);
            xfer = data_valid && data_ready;
            fin  = done;
            @(posedge prog_clk); #1;
            start = 1'b0;
            if (xfer) begin
                idx++;
                if (idx == stall_after) stall = 10;
                if (idx == abort_at) begin
                    // Now in the first SHIFT cycle of this word; pulse reset in the third.
                    @(posedge prog_clk); #1;
                    @(posedge prog_clk); #1;
                    pReset     = 1'b1;
                    data_valid = 1'b0;
                    @(posedge prog_clk); #1;
                    check_reset_outputs({tag, "_abort"});
                    pReset = 1'b0;
                    return;
                end
            end
            if (stall > 0) begin
                data_valid = 1'b0;
                if (glitch && stall == 2) start = 1'b1;
                stall--;
            end else begin
                data_valid = (idx < NW);
            end
            data_in = (idx < NW) ? words[idx] : '0;
            if (glitch && !g2 && sh_cnt == L + 10) begin
                start = 1'b1;
                g2    = 1'b1;
            end
        end
        data_valid = 1'b0;
        start      = 1'b0;
        if (!fin) check_val({tag, "_timeout"}, 64'd0, 64'd1);
        repeat (4) @(posedge prog_clk);
        #1;
        mask     = '0;
        mask[20] = 1'b1;
        exp_load = stream_image() ^ (flip ? mask : '0);
        ok_exp   = v && (crc_seq(stream_image()) == crc_seq(exp_load));
        check_val({tag, "_shift_cycles"}, 64'(sh_cnt), 64'(v ? 2 * L : L));
        check_val({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check_val({tag, "_load_image"}, 64'(load_img), 64'(exp_load));
        check_val({tag, "_final_chain"}, 64'(chain), 64'(exp_load));
        check_val({tag, "_verify_ok"}, 64'(verify_ok), 64'(ok_exp));
        check_val({tag, "_verify_err"}, 64'(verify_err), 64'(v && !ok_exp));
        check_val({tag, "_head_idle_zero"}, 64'(head_viol), 64'd0);
        check_val({tag, "_no_shift_in_load"}, 64'(rs_viol), 64'd0);
        check_val({tag, "_ready_gap"}, 64'(gap_err), 64'd0);
        check_val({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic new_words();
        for (int i = 0; i < NW; i++) words[i] = W'($urandom);
    endtask

    initial begin
        repeat (3) @(posedge prog_clk);
        #1;
        check_reset_outputs("reset");
        pReset = 1'b0;
        new_words();
        run_load("plain", 1'b0, 1'b0, -1, 1'b0, -1);
        run_load("verify", 1'b1, 1'b0, -1, 1'b0, -1);
        run_load("flip20", 1'b1, 1'b1, -1, 1'b0, -1);
        run_load("stall", 1'b0, 1'b0, 3, 1'b0, -1);
        run_load("start_glitch", 1'b1, 1'b0, 3, 1'b1, -1);
        run_load("abort", 1'b1, 1'b0, -1, 1'b0, 4);
        new_words();
        run_load("reload", 1'b1, 1'b0, -1, 1'b0, -1);
        for (int r = 0; r < 3; r++) begin
            new_words();
            run_load("random", 1'($urandom_range(0, 1)), 1'b0, -1, 1'b0, -1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 58, giving the number of configuration-chain flops driven (cby_0__1_ chain: 9x6 + 2x2 bits).
REQ-002 SHALL have parameter WORD_W, default 8, giving the bitstream input word width.
REQ-003 SHALL have port prog_clk  in  1  single clock, rising edge; all state changes on this edge.
REQ-004 SHALL have port pReset  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  in  1  begin load; sampled in IDLE only.
REQ-006 SHALL have port verify_en  in  1  request readback check; captured when start is accepted.
REQ-007 SHALL have port data_in  in  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
REQ-008 SHALL have port data_valid  in  1  data_in valid.
REQ-009 SHALL have port data_ready  out  1  loader accepts data_in; a transfer occurs when data_valid and data_ready are both 1.
REQ-010 SHALL have port ccff_head  out  1  serial data to the chain head.
REQ-011 SHALL have port ccff_shift_en  out  1  chain clock enable; the chain advances on an edge only if this is 1 in that cycle.
REQ-012 SHALL have port ccff_tail  in  1  chain tail output; combinational from the last chain flop.
REQ-013 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-014 SHALL have port done  out  1  one-cycle completion pulse.
REQ-015 SHALL have ports verify_ok and verify_err  out  1 each  readback result; held until the next accepted start.

Function
REQ-016 SHALL implement the states IDLE, LOAD, SHIFT, VERIFY, CHECK and FIN.
REQ-017 In IDLE, start=1 SHALL clear verify_ok, verify_err and the bit counter, capture verify_en, and enter LOAD on the next cycle.
REQ-018 start SHALL be ignored in every state other than IDLE.
REQ-019 data_ready SHALL be 1 only in LOAD; in LOAD, ccff_shift_en SHALL be 0.
REQ-020 A transfer SHALL latch data_in and enter SHIFT with k = min(WORD_W, CHAIN_LEN - bits_sent).
REQ-021 SHIFT SHALL last exactly k cycles, each with ccff_shift_en=1 and ccff_head set to the next latched bit, MSB first.
REQ-022 Unused low bits of the final partial word SHALL be discarded.
REQ-023 After SHIFT, the block SHALL return to LOAD if bits_sent < CHAIN_LEN; otherwise it SHALL go to VERIFY if verify was captured, else to FIN.
REQ-024 This gives one bubble cycle per word: a word accepted in cycle A shifts in A+1..A+k, and data_ready reasserts in A+k+1.
REQ-025 data_valid low in LOAD SHALL stall the block indefinitely with no shift.
REQ-026 Each bit driven during SHIFT SHALL update CRC_TX: CRC-16-CCITT, polynomial 0x1021, init 0xFFFF, bit-serial, MSB first.
REQ-027 VERIFY SHALL last exactly CHAIN_LEN cycles, each with ccff_shift_en=1 and ccff_head=ccff_tail (recirculation), so chain contents are restored afterward.
REQ-028 Each ccff_tail value sampled in a VERIFY cycle SHALL update CRC_RX with the same algorithm.
REQ-029 CHECK SHALL last 1 cycle and set verify_ok=(CRC_TX==CRC_RX) and verify_err=!verify_ok.
REQ-030 FIN SHALL last 1 cycle with done=1, then the block SHALL return to IDLE.
REQ-031 Without verify, verify_ok and verify_err SHALL both remain 0.
REQ-032 The bit counter SHALL be clog2(CHAIN_LEN+1) bits wide, SHALL never exceed CHAIN_LEN, and SHALL be reused to count VERIFY cycles.
REQ-033 ccff_shift_en SHALL be 1 for exactly CHAIN_LEN cycles per load, or 2*CHAIN_LEN with verify.
REQ-034 ccff_head SHALL be 0 whenever ccff_shift_en=0.
REQ-035 All outputs SHALL be registered.

Reset
REQ-036 pReset=1 at a rising edge SHALL, from any state, force IDLE and set data_ready, ccff_head, ccff_shift_en, busy, done, verify_ok and verify_err to 0.
REQ-037 pReset=1 SHALL clear the counters and set both CRCs to 0xFFFF.
REQ-038 pReset SHALL take priority over start and over any transfer in the same cycle.
REQ-039 After reset during SHIFT or VERIFY, chain contents are undefined, and a new start SHALL perform a full reload.

Verification
REQ-040 Defaults, 8 words, verify_en=0, 58-flop chain model -> 58 shift_en cycles, word 8 contributes only bits 7:6, done occurs once, chain matches the stream.
REQ-041 Same stream with verify_en=1 -> 116 shift_en cycles, verify_ok=1, verify_err=0, chain contents identical before and after VERIFY.
REQ-042 Model flips chain bit 20 after load -> verify_err=1, verify_ok=0.
REQ-043 data_valid low for 10 cycles after word 3 -> shift_en=0 throughout the stall, final chain image unchanged versus the unstalled run.
REQ-044 pReset pulsed in the 3rd SHIFT cycle of word 4 -> next cycle all outputs 0 and busy=0; a subsequent full load completes correctly.
REQ-045 start pulsed during LOAD and during VERIFY -> no effect; exactly one done pulse.
